// File: rtl/mul_sched_pkg.sv
// Shared types and helpers for the multiplier round-robin scheduler.
package mul_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } sched_state_e;

   // Index width for n items; never below one bit so single-entry vectors stay legal.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr_i, with wrap.
module rr_arbiter
   import mul_sched_pkg::*;
#(
   parameter  int unsigned N  = 4,
   localparam int unsigned IW = idx_width(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] grant_idx_o,
   output logic          any_o
);

   always_comb begin
      int unsigned   pos;
      logic [IW-1:0] idx;
      grant_o     = '0;
      grant_idx_o = '0;
      any_o       = 1'b0;
      pos         = 0;
      idx         = '0;
      for (int unsigned k = 0; k < N; k++) begin
         pos = 32'(ptr_i) + k;
         if (pos >= N) pos = pos - N;
         idx = IW'(pos);
         if (!any_o && req_i[idx]) begin
            any_o        = 1'b1;
            grant_o[idx] = 1'b1;
            grant_idx_o  = idx;
         end
      end
   end

endmodule

// File: rtl/mul_rr_scheduler.sv
// Time-shares one combinational multiplier between NREQ requesters with round-robin
// arbitration; operands are held MUL_LAT cycles before the product is sampled.
module mul_rr_scheduler
   import mul_sched_pkg::*;
#(
   parameter  int unsigned WIDTH   = 6,
   parameter  int unsigned NREQ    = 4,
   parameter  int unsigned MUL_LAT = 1,
   localparam int unsigned IDW     = idx_width(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [WIDTH-1:0]      mul_in1,
   output logic [WIDTH-1:0]      mul_in2,
   input  logic [2*WIDTH-1:0]    mul_out,
   input  logic                  mul_overflow,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [IDW-1:0]        resp_id,
   output logic [2*WIDTH-1:0]    resp_prod,
   output logic                  resp_ovf,
   output logic                  busy
);

   localparam int unsigned CW = idx_width(MUL_LAT);
   localparam int unsigned PW = 2 * WIDTH;

   sched_state_e   state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0] id_q, id_d;
   logic [WIDTH-1:0] in1_q, in1_d, in2_q, in2_d;
   logic           resp_valid_q, resp_valid_d;
   logic [IDW-1:0] resp_id_q, resp_id_d;
   logic [PW-1:0]  resp_prod_q, resp_prod_d;
   logic           resp_ovf_q, resp_ovf_d;

   logic [NREQ-1:0]  grant;
   logic [IDW-1:0]   grant_idx;
   logic             grant_any;
   logic [WIDTH-1:0] sel_a, sel_b;

   rr_arbiter #(.N(NREQ)) u_arb (
      .req_i       (req_valid),
      .ptr_i       (rr_ptr_q),
      .grant_o     (grant),
      .grant_idx_o (grant_idx),
      .any_o       (grant_any)
   );

   // One-hot operand mux driven by the arbiter grant.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_a = req_a[i*WIDTH +: WIDTH];
            sel_b = req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   assign req_ready  = (state_q == IDLE) ? grant : '0;
   assign busy       = (state_q != IDLE);
   assign mul_in1    = in1_q;
   assign mul_in2    = in2_q;
   assign resp_valid = resp_valid_q;
   assign resp_id    = resp_id_q;
   assign resp_prod  = resp_prod_q;
   assign resp_ovf   = resp_ovf_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rr_ptr_d     = rr_ptr_q;
      id_d         = id_q;
      in1_d        = in1_q;
      in2_d        = in2_q;
      resp_valid_d = resp_valid_q;
      resp_id_d    = resp_id_q;
      resp_prod_d  = resp_prod_q;
      resp_ovf_d   = resp_ovf_q;
      case (state_q)
         IDLE: begin
            if (grant_any) begin
               in1_d    = sel_a;
               in2_d    = sel_b;
               id_d     = grant_idx;
               rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
               cnt_d    = CW'(MUL_LAT - 1);
               state_d  = WAIT;
            end
         end
         WAIT: begin
            // Multicycle path: product sampled only after the count has run down.
            if (cnt_q == '0) begin
               resp_prod_d  = mul_out;
               resp_ovf_d   = mul_overflow;
               resp_id_d    = id_q;
               resp_valid_d = 1'b1;
               state_d      = RESP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         rr_ptr_q     <= '0;
         id_q         <= '0;
         in1_q        <= '0;
         in2_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
         resp_prod_q  <= '0;
         resp_ovf_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rr_ptr_q     <= rr_ptr_d;
         id_q         <= id_d;
         in1_q        <= in1_d;
         in2_q        <= in2_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         resp_prod_q  <= resp_prod_d;
         resp_ovf_q   <= resp_ovf_d;
      end
   end

endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Bench for mul_rr_scheduler: two instances (MUL_LAT=1 and 3) with an exact multiplier stub,
// checked against a request-level round-robin model.
module tb_mul_rr_scheduler;

   localparam int W = 6;
   localparam int N = 4;

   logic clk;
   logic             rst_n      [2];
   logic [N-1:0]     req_valid  [2];
   logic [N-1:0]     req_ready  [2];
   logic [N*W-1:0]   req_a      [2];
   logic [N*W-1:0]   req_b      [2];
   logic [W-1:0]     mul_in1    [2];
   logic [W-1:0]     mul_in2    [2];
   logic [2*W-1:0]   mul_out    [2];
   logic             mul_ovf    [2];
   logic             resp_valid [2];
   logic             resp_ready [2];
   logic [1:0]       resp_id    [2];
   logic [2*W-1:0]   resp_prod  [2];
   logic             resp_ovf   [2];
   logic             busy       [2];

   int n_tests = 0;
   int n_fail  = 0;
   int model_ptr [2];
   int op_a [2][N];
   int op_b [2][N];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Exact multiplier stubs; overflow flag = product MSB.
   assign mul_out[0] = (2*W)'(mul_in1[0]) * (2*W)'(mul_in2[0]);
   assign mul_ovf[0] = mul_out[0][2*W-1];
   assign mul_out[1] = (2*W)'(mul_in1[1]) * (2*W)'(mul_in2[1]);
   assign mul_ovf[1] = mul_out[1][2*W-1];

   mul_rr_scheduler #(.WIDTH(W), .NREQ(N), .MUL_LAT(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_a(req_a[0]), .req_b(req_b[0]), .mul_in1(mul_in1[0]), .mul_in2(mul_in2[0]),
      .mul_out(mul_out[0]), .mul_overflow(mul_ovf[0]), .resp_valid(resp_valid[0]),
      .resp_ready(resp_ready[0]), .resp_id(resp_id[0]), .resp_prod(resp_prod[0]),
      .resp_ovf(resp_ovf[0]), .busy(busy[0]));

   mul_rr_scheduler #(.WIDTH(W), .NREQ(N), .MUL_LAT(3)) u_dut1 (
      .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_a(req_a[1]), .req_b(req_b[1]), .mul_in1(mul_in1[1]), .mul_in2(mul_in2[1]),
      .mul_out(mul_out[1]), .mul_overflow(mul_ovf[1]), .resp_valid(resp_valid[1]),
      .resp_ready(resp_ready[1]), .resp_id(resp_id[1]), .resp_prod(resp_prod[1]),
      .resp_ovf(resp_ovf[1]), .busy(busy[1]));

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   // Reference arbitration: first pending requester at or after ptr, wrapping.
   function automatic int pick(input logic [N-1:0] m, input int p);
      for (int k = 0; k < N; k++) begin
         if (m[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic set_op(input int d, input int r, input int a, input int b);
      op_a[d][r] = a;
      op_b[d][r] = b;
      req_a[d][r*W +: W] = W'(a);
      req_b[d][r*W +: W] = W'(b);
   endtask

   task automatic do_reset(input int d);
      rst_n[d] = 1'b0;
      req_valid[d] = '0;
      resp_ready[d] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n[d] = 1'b1;
      model_ptr[d] = 0;
      #1;
   endtask

   // Present mask and wait for a grant; returns at the negedge after the handshake edge.
   task automatic grant_req(input int d, input logic [N-1:0] mask, output int g, output int waits);
      req_valid[d] = mask;
      #1;
      waits = 0;
      g = -1;
      while (req_ready[d] == '0 && waits < 20) begin
         @(negedge clk); #1; waits++;
      end
      for (int k = 0; k < N; k++) if (req_ready[d][k]) g = k;
      @(negedge clk);
      if (g >= 0) req_valid[d][g] = 1'b0;
      #1;
   endtask

   // Edges after the handshake edge until resp_valid is seen; -1 on timeout.
   task automatic wait_resp(input int d, output int edges);
      edges = 0;
      while (!resp_valid[d] && edges < 40) begin
         @(negedge clk); #1; edges++;
      end
      if (!resp_valid[d]) edges = -1;
   endtask

   task automatic ack(input int d);
      resp_ready[d] = 1'b1;
      @(negedge clk);
      resp_ready[d] = 1'b0;
      #1;
   endtask

   task automatic test_reset(input int d);
      rst_n[d] = 1'b0;
      req_valid[d] = '0;
      resp_ready[d] = 1'b0;
      #1;
      n_tests++;
      if ({mul_in1[d], mul_in2[d], resp_valid[d], resp_id[d], resp_prod[d], resp_ovf[d],
           req_ready[d], busy[d]} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs d%0d: got in1=%0d in2=%0d rv=%b id=%0d prod=%0d busy=%b, required all 0",
                  d, mul_in1[d], mul_in2[d], resp_valid[d], resp_id[d], resp_prod[d], busy[d]);
      end
      @(negedge clk);
      rst_n[d] = 1'b1;
      model_ptr[d] = 0;
      @(negedge clk); #1;
      n_tests++;
      if (busy[d] !== 1'b0 || resp_valid[d] !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle d%0d: got busy=%b rv=%b, required 0 0", d, busy[d], resp_valid[d]);
      end
   endtask

   task automatic test_single(input int d);
      int g, w, e, exp;
      set_op(d, 2, 5, 7);
      exp = pick(4'b0100, model_ptr[d]);
      model_ptr[d] = (exp + 1) % N;
      grant_req(d, 4'b0100, g, w);
      n_tests++;
      if (g !== 2) begin n_fail++; $display("FAIL single_grant d%0d: got %0d required 2", d, g); end
      n_tests++;
      if (mul_in1[d] !== 6'd5 || mul_in2[d] !== 6'd7 || busy[d] !== 1'b1) begin
         n_fail++;
         $display("FAIL single_operands d%0d: got %0d,%0d busy=%b required 5,7 busy=1",
                  d, mul_in1[d], mul_in2[d], busy[d]);
      end
      wait_resp(d, e);
      n_tests++;
      if (e !== lat_of(d)) begin n_fail++; $display("FAIL single_latency d%0d: got %0d required %0d", d, e, lat_of(d)); end
      n_tests++;
      if (resp_id[d] !== 2'd2 || resp_prod[d] !== 12'd35 || resp_ovf[d] !== 1'b0 || busy[d] !== 1'b1) begin
         n_fail++;
         $display("FAIL single_resp d%0d: got id=%0d prod=%0d ovf=%b busy=%b required 2 35 0 1",
                  d, resp_id[d], resp_prod[d], resp_ovf[d], busy[d]);
      end
      ack(d);
      n_tests++;
      if (resp_valid[d] !== 1'b0 || busy[d] !== 1'b0 || resp_prod[d] !== 12'd35) begin
         n_fail++;
         $display("FAIL single_after_ack d%0d: got rv=%b busy=%b prod=%0d required 0 0 35",
                  d, resp_valid[d], busy[d], resp_prod[d]);
      end
   endtask

   task automatic test_all_four(input int d);
      logic [N-1:0] pend;
      int g, w, e, exp, p;
      do_reset(d);
      for (int r = 0; r < N; r++) set_op(d, r, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
      pend = 4'hF;
      for (int i = 0; i < 6; i++) begin
         if (pend == '0) pend = N'($urandom_range(1, 15));
         exp = pick(pend, model_ptr[d]);
         model_ptr[d] = (exp + 1) % N;
         grant_req(d, pend, g, w);
         n_tests++;
         if (g !== exp || (i < 4 && g !== i)) begin
            n_fail++; $display("FAIL rr_grant d%0d op%0d: got %0d required %0d", d, i, g, exp);
         end
         if (i > 0) begin
            n_tests++;
            if (w !== 0) begin n_fail++; $display("FAIL rr_b2b d%0d op%0d: got %0d wait cycles required 0", d, i, w); end
         end
         if (exp >= 0) pend[exp] = 1'b0;
         req_valid[d] = pend;
         wait_resp(d, e);
         p = op_a[d][exp] * op_b[d][exp];
         n_tests++;
         if (e !== lat_of(d) || resp_id[d] !== 2'(exp) || resp_prod[d] !== 12'(p) || resp_ovf[d] !== (p >= 2048)) begin
            n_fail++;
            $display("FAIL rr_resp d%0d op%0d: got lat=%0d id=%0d prod=%0d ovf=%b required %0d %0d %0d %b",
                     d, i, e, resp_id[d], resp_prod[d], resp_ovf[d], lat_of(d), exp, p, p >= 2048);
         end
         ack(d);
      end
      req_valid[d] = '0;
   endtask

   task automatic test_max(input int d);
      int r, g, w, e, exp;
      int av [2] = '{63, 0};
      int pv [2] = '{3969, 0};
      r = int'($urandom_range(0, N - 1));
      for (int i = 0; i < 2; i++) begin
         set_op(d, r, av[i], 63);
         exp = pick(N'(1 << r), model_ptr[d]);
         model_ptr[d] = (exp + 1) % N;
         grant_req(d, N'(1 << r), g, w);
         wait_resp(d, e);
         n_tests++;
         if (g !== exp || resp_prod[d] !== 12'(pv[i]) || resp_ovf[d] !== (pv[i] >= 2048) || resp_id[d] !== 2'(r)) begin
            n_fail++;
            $display("FAIL max_operands d%0d a=%0d: got g=%0d prod=%0d ovf=%b required %0d %0d %b",
                     d, av[i], g, resp_prod[d], resp_ovf[d], exp, pv[i], pv[i] >= 2048);
         end
         ack(d);
      end
   endtask

   task automatic test_backpressure(input int d);
      int r1, r2, g, w, e, exp, p;
      r1 = int'($urandom_range(0, N - 1));
      r2 = (r1 + 1 + int'($urandom_range(0, 2))) % N;
      set_op(d, r1, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
      set_op(d, r2, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
      exp = pick(N'(1 << r1), model_ptr[d]);
      model_ptr[d] = (exp + 1) % N;
      grant_req(d, N'(1 << r1), g, w);
      req_valid[d][r2] = 1'b1;
      wait_resp(d, e);
      p = op_a[d][r1] * op_b[d][r1];
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); #1;
         n_tests++;
         if (resp_valid[d] !== 1'b1 || resp_prod[d] !== 12'(p) || resp_id[d] !== 2'(r1) ||
             req_ready[d] !== '0 || busy[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_stall d%0d c%0d: got rv=%b prod=%0d id=%0d rdy=%b busy=%b required 1 %0d %0d 0000 1",
                     d, c, resp_valid[d], resp_prod[d], resp_id[d], req_ready[d], busy[d], p, r1);
         end
      end
      ack(d);
      exp = pick(req_valid[d], model_ptr[d]);
      model_ptr[d] = (exp + 1) % N;
      grant_req(d, req_valid[d], g, w);
      n_tests++;
      if (g !== r2 || w !== 0) begin
         n_fail++; $display("FAIL bp_next_grant d%0d: got g=%0d wait=%0d required %0d 0", d, g, w, r2);
      end
      wait_resp(d, e);
      p = op_a[d][r2] * op_b[d][r2];
      n_tests++;
      if (resp_prod[d] !== 12'(p) || resp_id[d] !== 2'(r2)) begin
         n_fail++; $display("FAIL bp_next_resp d%0d: got %0d id %0d required %0d id %0d", d, resp_prod[d], resp_id[d], p, r2);
      end
      ack(d);
      req_valid[d] = '0;
   endtask

   task automatic test_fairness(input int d);
      int g, w, e, exp;
      int order [3] = '{1, 3, 1};
      logic [N-1:0] masks [3] = '{4'b0010, 4'b1010, 4'b0010};
      set_op(d, 1, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
      set_op(d, 3, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
      for (int i = 0; i < 3; i++) begin
         exp = pick(masks[i], model_ptr[d]);
         model_ptr[d] = (exp + 1) % N;
         grant_req(d, (i == 2) ? (req_valid[d] | masks[i]) : masks[i], g, w);
         n_tests++;
         if (g !== exp || g !== order[i]) begin
            n_fail++; $display("FAIL fair_grant d%0d step%0d: got %0d required %0d", d, i, g, order[i]);
         end
         wait_resp(d, e);
         n_tests++;
         if (resp_id[d] !== 2'(order[i]) || resp_prod[d] !== 12'(op_a[d][order[i]] * op_b[d][order[i]])) begin
            n_fail++; $display("FAIL fair_resp d%0d step%0d: got id=%0d prod=%0d required id=%0d", d, i, resp_id[d], resp_prod[d], order[i]);
         end
         ack(d);
      end
      req_valid[d] = '0;
   endtask

   task automatic test_reset_mid(input int d);
      int r, g, w, e, exp;
      logic [N-1:0] mask;
      r = int'($urandom_range(1, N - 1));
      set_op(d, r, int'($urandom_range(1, 63)), int'($urandom_range(1, 63)));
      grant_req(d, N'(1 << r), g, w);
      req_valid[d] = '0;
      rst_n[d] = 1'b0;
      #1;
      n_tests++;
      if ({mul_in1[d], mul_in2[d], resp_valid[d], resp_id[d], resp_prod[d], resp_ovf[d],
           req_ready[d], busy[d]} !== '0) begin
         n_fail++;
         $display("FAIL midreset_outputs d%0d: got in1=%0d in2=%0d rv=%b prod=%0d busy=%b required all 0",
                  d, mul_in1[d], mul_in2[d], resp_valid[d], resp_prod[d], busy[d]);
      end
      @(negedge clk);
      rst_n[d] = 1'b1;
      model_ptr[d] = 0;
      #1;
      for (int c = 0; c < lat_of(d) + 3; c++) begin
         @(negedge clk); #1;
         n_tests++;
         if (resp_valid[d] !== 1'b0 || busy[d] !== 1'b0) begin
            n_fail++; $display("FAIL midreset_stale d%0d c%0d: got rv=%b busy=%b required 0 0", d, c, resp_valid[d], busy[d]);
         end
      end
      mask = N'($urandom_range(1, 15));
      for (int k = 0; k < N; k++) set_op(d, k, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
      exp = pick(mask, 0);
      model_ptr[d] = (exp + 1) % N;
      grant_req(d, mask, g, w);
      n_tests++;
      if (g !== exp) begin n_fail++; $display("FAIL midreset_grant d%0d mask=%b: got %0d required %0d", d, mask, g, exp); end
      req_valid[d] = '0;
      wait_resp(d, e);
      n_tests++;
      if (e !== lat_of(d) || resp_prod[d] !== 12'(op_a[d][exp] * op_b[d][exp])) begin
         n_fail++; $display("FAIL midreset_resp d%0d: got lat=%0d prod=%0d required %0d %0d",
                            d, e, resp_prod[d], lat_of(d), op_a[d][exp] * op_b[d][exp]);
      end
      ack(d);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst_n[d] = 1'b0;
         req_valid[d] = '0;
         resp_ready[d] = 1'b0;
         req_a[d] = '0;
         req_b[d] = '0;
         model_ptr[d] = 0;
      end
      @(negedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         test_reset(d);
         test_single(d);
         test_all_four(d);
         test_max(d);
         test_backpressure(d);
         test_fairness(d);
         test_reset_mid(d);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
